// File: rtl/rv_pkg.sv
// Shared types and constants for the instruction fetch stage.
package rv_pkg;

  // Canonical NOP (addi x0, x0, 0) delivered in place of a faulting fetch.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Width of the fetch-side occupancy counters; large enough for DEPTH up to 8.
  localparam int CNT_W = 4;

  typedef enum logic {
    FETCH_RUN,
    FETCH_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// Prefetch FIFO holding returned instruction words until the core takes them.
// A flush empties it outright and overrides any push or pop in the same cycle.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Next-state for storage, pointers and count; a pop frees its slot for a same-cycle push.
  always_comb begin
    do_pop   = pop && (count_q != '0) && !flush;
    do_push  = push && !flush && ((count_q != FULL_CNT) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Register FIFO state; reset leaves it empty with cleared storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // The upstream credit scheme must never push into a full FIFO without a pop.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && !flush && (count_q == FULL_CNT) && !do_pop));
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/rv_fetch.sv
// Instruction fetch stage: issues word reads on the instruction bus, buffers the
// in-order responses in a prefetch FIFO and restarts cleanly on core redirects.
module rv_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int SUM_W = CNT_W + 2;

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;
  logic             grant, accept, drop_resp, push, pop;
  logic [SUM_W-1:0] credit_used;
  logic [31:0]      redirect_addr;

  // Bus request and handshake decode; requests, late responses and buffered words share one credit pool.
  always_comb begin
    credit_used   = SUM_W'(outstanding_q) + SUM_W'(drop_cnt_q) + SUM_W'(fifo_count);
    bus_req       = !rst && (state_q == FETCH_RUN) && !redirect_valid &&
                    (credit_used < SUM_W'(DEPTH));
    bus_addr      = fetch_pc_q;
    grant         = bus_req && bus_gnt;
    drop_resp     = bus_rvalid && (drop_cnt_q != '0);
    accept        = bus_rvalid && (drop_cnt_q == '0);
    push          = accept && !redirect_valid;
    pop           = !fifo_empty && if_ready;
    redirect_addr = redirect_pc & 32'hFFFF_FFFC;
    push_entry.pc    = resp_pc_q;
    push_entry.instr = bus_err ? NOP_INSTR : bus_rdata;
    push_entry.fault = bus_err;
  end

  // Core-facing view of the FIFO head, forced to zero while nothing is buffered.
  always_comb begin
    if_valid = !fifo_empty;
    if_pc    = fifo_empty ? 32'h0 : fifo_head.pc;
    if_instr = fifo_empty ? 32'h0 : fifo_head.instr;
    if_fault = !fifo_empty && fifo_head.fault;
  end

  // Next-state for fetch/response PCs, counters and run/halt; a redirect overrides everything.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if (redirect_valid) begin
      state_d       = FETCH_RUN;
      fetch_pc_d    = redirect_addr;
      resp_pc_d     = redirect_addr;
      outstanding_d = '0;
      drop_cnt_d    = drop_cnt_q + outstanding_q + CNT_W'(grant) - CNT_W'(bus_rvalid);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(accept);
      if (drop_resp) drop_cnt_d = drop_cnt_q - 1'b1;
      if (accept) begin
        resp_pc_d = resp_pc_q + 32'd4;
        if (bus_err) state_d = FETCH_HALT;
      end
    end
  end

  // Register fetch state; reset restarts fetching at RESET_PC with nothing in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH_RUN;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // A response with nothing requested or pending-drop means the bus broke protocol.
  always_ff @(posedge clk) begin
    if (!rst && bus_rvalid) assert ((outstanding_q != '0) || (drop_cnt_q != '0));
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
